// File: rtl/feeder_pkg.sv
// Shared types and constants for the row feeder.
// Holds the feeder state encoding, the tile instruction codes driven on
// inst_w, and the beat counter width.
package feeder_pkg;

    // Beat counter width: enough for 2*255 execute beats.
    localparam int unsigned CNT_W = $clog2(512);

    localparam logic [1:0] INST_NOP  = 2'b00;
    localparam logic [1:0] INST_LOAD = 2'b01;
    localparam logic [1:0] INST_EXEC = 2'b10;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_LOAD = 2'd1,
        ST_EXEC = 2'd2,
        ST_DONE = 2'd3
    } state_t;

endpackage

// File: rtl/row_feeder.sv
// row_feeder: streams kernel weights, then activation pairs, from an
// upstream buffer into the west edge of a row of mac_tiles.
//
// Ports:
//   clk, reset         clock and synchronous active-high reset
//   in_data/in_valid   upstream beat; in_ready says the feeder takes it
//   start_load         pulse: load 2*col kernel beats (only if not loaded)
//   start_exec         pulse: execute 2*cfg_pairs beats (only if loaded)
//   cfg_pairs          activation pair count, sampled with start_exec
//   out_w, inst_w      registered data/instruction to tile 0
//   busy               state is LOAD or EXEC
//   done               one-cycle pulse at phase completion
//   loaded             kernel load completed since reset
//   stall_cnt          (FEEDER_STALL_CNT_EN only) saturating count of
//                      cycles the feeder was ready but got no data
//
// Build option: define FEEDER_STALL_CNT_EN to add the stall_cnt port.
module row_feeder
    import feeder_pkg::*;
#(
    parameter int unsigned bw  = 4,
    parameter int unsigned col = 8
) (
    input  logic          clk,
    input  logic          reset,
    input  logic [bw-1:0] in_data,
    input  logic          in_valid,
    output logic          in_ready,
    input  logic          start_load,
    input  logic          start_exec,
    input  logic [7:0]    cfg_pairs,
    output logic [bw-1:0] out_w,
    output logic [1:0]    inst_w,
    output logic          busy,
    output logic          done,
    output logic          loaded
`ifdef FEEDER_STALL_CNT_EN
    ,
    output logic [15:0]   stall_cnt
`endif
);

    localparam logic [CNT_W-1:0] LOAD_BEATS = CNT_W'(2 * col);

    state_t           state;
    logic [CNT_W-1:0] beats_left;
    logic             xfer_c;
    logic             last_c;

    assign xfer_c = in_valid && in_ready;
    assign last_c = xfer_c && (beats_left == CNT_W'(1));
    assign busy   = (state == ST_LOAD) || (state == ST_EXEC);

    // Feeder FSM, beat counter and registered tile outputs.
    always_ff @(posedge clk) begin
        if (reset) begin
            state      <= ST_IDLE;
            beats_left <= '0;
            in_ready   <= 1'b0;
            out_w      <= '0;
            inst_w     <= INST_NOP;
            done       <= 1'b0;
            loaded     <= 1'b0;
        end else begin
            // No transfer means a NOP instruction with out_w held, so the
            // tile's pair counter never advances on a stall.
            inst_w <= INST_NOP;
            done   <= 1'b0;

            if (xfer_c) begin
                out_w      <= in_data;
                inst_w     <= (state == ST_LOAD) ? INST_LOAD : INST_EXEC;
                beats_left <= beats_left - CNT_W'(1);
            end

            case (state)
                ST_IDLE: begin
                    // start_load takes priority; a coincident start_exec is dropped.
                    if (start_load) begin
                        if (!loaded) begin
                            state      <= ST_LOAD;
                            beats_left <= LOAD_BEATS;
                            in_ready   <= 1'b1;
                        end
                    end else if (start_exec && loaded) begin
                        if (cfg_pairs == 8'd0) begin
                            state <= ST_DONE;
                            done  <= 1'b1;
                        end else begin
                            state      <= ST_EXEC;
                            beats_left <= {cfg_pairs, 1'b0};
                            in_ready   <= 1'b1;
                        end
                    end
                end
                ST_LOAD, ST_EXEC: begin
                    if (last_c) begin
                        state    <= ST_DONE;
                        in_ready <= 1'b0;
                        done     <= 1'b1;
                        if (state == ST_LOAD) begin
                            loaded <= 1'b1;
                        end
                    end
                end
                ST_DONE: begin
                    state <= ST_IDLE;
                end
                default: begin
                    state <= ST_IDLE;
                end
            endcase
        end
    end

`ifdef FEEDER_STALL_CNT_EN
    logic start_acc_c;

    assign start_acc_c = (state == ST_IDLE) &&
                         ((start_load && !loaded) ||
                          (!start_load && start_exec && loaded));

    // Saturating count of ready-but-starved cycles, cleared per phase start.
    always_ff @(posedge clk) begin
        if (reset) begin
            stall_cnt <= '0;
        end else if (start_acc_c) begin
            stall_cnt <= '0;
        end else if (busy && in_ready && !in_valid && (stall_cnt != 16'hFFFF)) begin
            stall_cnt <= stall_cnt + 16'd1;
        end
    end
`endif

endmodule

// File: tb/tb_row_feeder.sv
// Self-checking bench for row_feeder: directed sequences, a vector table
// for start-pulse corner cases, and randomized traffic checked against a
// phase-level reference model.
module tb_row_feeder;

    localparam int unsigned BW  = 4;
    localparam int unsigned COL = 8;

    logic          clk = 1'b0;
    logic          reset;
    logic [BW-1:0] in_data;
    logic          in_valid;
    logic          in_ready;
    logic          start_load;
    logic          start_exec;
    logic [7:0]    cfg_pairs;
    logic [BW-1:0] out_w;
    logic [1:0]    inst_w;
    logic          busy;
    logic          done;
    logic          loaded;
`ifdef FEEDER_STALL_CNT_EN
    logic [15:0]   stall_cnt;
`endif

    row_feeder #(.bw(BW), .col(COL)) dut (
        .clk        (clk),
        .reset      (reset),
        .in_data    (in_data),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .start_load (start_load),
        .start_exec (start_exec),
        .cfg_pairs  (cfg_pairs),
        .out_w      (out_w),
        .inst_w     (inst_w),
        .busy       (busy),
        .done       (done),
        .loaded     (loaded)
`ifdef FEEDER_STALL_CNT_EN
        ,
        .stall_cnt  (stall_cnt)
`endif
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_pass   = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp)
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        else
            n_pass++;
    endtask

    // Reference model: phase name, beats still owed, and the outputs the
    // spec says must be visible after the next edge.
    int          m_phase;   // 0 idle, 1 load, 2 exec, 3 done
    int          m_left;
    bit          m_loaded;
    bit          m_done;
    logic [1:0]  m_inst;
    logic [BW-1:0] m_out;
    int          m_stall;

    task automatic model_edge();
        bit taking;
        if (reset) begin
            m_phase = 0; m_left = 0; m_loaded = 0; m_done = 0;
            m_inst = 2'b00; m_out = '0; m_stall = 0;
            return;
        end
        taking = in_valid && (m_phase == 1 || m_phase == 2);
        m_done = 0;
        m_inst = 2'b00;
        if (taking) begin
            m_out  = in_data;
            m_inst = (m_phase == 1) ? 2'b01 : 2'b10;
            m_left = m_left - 1;
        end
        case (m_phase)
            0: begin
                if (start_load) begin
                    if (!m_loaded) begin
                        m_phase = 1; m_left = 2 * COL; m_stall = 0;
                    end
                end else if (start_exec && m_loaded) begin
                    m_stall = 0;
                    if (cfg_pairs == 0) begin
                        m_phase = 3; m_done = 1;
                    end else begin
                        m_phase = 2; m_left = 2 * int'(cfg_pairs);
                    end
                end
            end
            1, 2: begin
                if (!in_valid && m_stall < 65535) m_stall++;
                if (m_left == 0) begin
                    if (m_phase == 1) m_loaded = 1;
                    m_phase = 3; m_done = 1;
                end
            end
            default: m_phase = 0;
        endcase
    endtask

    task automatic compare_all();
        bit m_busy;
        m_busy = (m_phase == 1 || m_phase == 2);
        check("in_ready", 32'(in_ready), 32'(m_busy));
        check("busy",     32'(busy),     32'(m_busy));
        check("out_w",    32'(out_w),    32'(m_out));
        check("inst_w",   32'(inst_w),   32'(m_inst));
        check("done",     32'(done),     32'(m_done));
        check("loaded",   32'(loaded),   32'(m_loaded));
`ifdef FEEDER_STALL_CNT_EN
        check("stall_cnt", 32'(stall_cnt), 32'(m_stall));
`endif
    endtask

    // One clock: model sees the same inputs as the DUT, outputs checked #1 later.
    task automatic step();
        model_edge();
        @(posedge clk);
        #1;
        compare_all();
        start_load = 1'b0;
        start_exec = 1'b0;
        in_data    = BW'($urandom);
    endtask

    // Feed beats until done, optionally starving the feeder for stall_len
    // cycles once stall_at beats have been observed.
    task automatic run_phase(input int stall_at, input int stall_len,
                             output int n_ld, output int n_ex);
        int  stalled = 0;
        bit  seen = 0;
        n_ld = 0; n_ex = 0;
        in_valid = 1'b1;
        for (int c = 0; c < 300; c++) begin
            step();
            if (inst_w == 2'b01) n_ld++;
            if (inst_w == 2'b10) n_ex++;
            if (done) begin seen = 1; break; end
            if ((n_ld + n_ex) == stall_at && stalled < stall_len) begin
                in_valid = 1'b0; stalled++;
            end else begin
                in_valid = 1'b1;
            end
        end
        if (!seen) check("phase_timeout", 32'd0, 32'd1);
    endtask

    typedef struct {
        bit         rst;
        bit         sl;
        bit         se;
        logic [7:0] cfg;
        bit         iv;
        logic [1:0] e_inst;
        bit         e_done;
        bit         e_busy;
        bit         e_loaded;
    } vec_t;

    vec_t tbl[8];

    initial begin
        int nl, ne;
        reset = 1'b1; in_data = '0; in_valid = 1'b0;
        start_load = 1'b0; start_exec = 1'b0; cfg_pairs = 8'd0;

        // Reset state
        step(); step();
        check("rst_inst",   32'(inst_w),   32'd0);
        check("rst_loaded", 32'(loaded),   32'd0);
        check("rst_ready",  32'(in_ready), 32'd0);
        reset = 1'b0;
        step();

        // Kernel load, in_valid held high
        start_load = 1'b1; in_valid = 1'b1;
        step();
        run_phase(-1, 0, nl, ne);
        check("load_beats", 32'(nl), 32'(2 * COL));
        check("load_loaded", 32'(loaded), 32'd1);
        step();
        check("done_one_cycle", 32'(done), 32'd0);

        // Two back-to-back executes of 3 pairs
        for (int k = 0; k < 2; k++) begin
            start_exec = 1'b1; cfg_pairs = 8'd3;
            step();
            run_phase(-1, 0, nl, ne);
            check("exec_beats", 32'(ne), 32'd6);
            step();
        end

        // Execute with a 2-cycle stall after the 3rd beat
        start_exec = 1'b1; cfg_pairs = 8'd3;
        step();
        run_phase(3, 2, nl, ne);
        check("stall_exec_beats", 32'(ne), 32'd6);
`ifdef FEEDER_STALL_CNT_EN
        check("stall_cnt_2", 32'(stall_cnt), 32'd2);
`endif
        step();

        // Start-pulse corner cases, one cycle per row
        tbl[0] = '{0, 1, 0, 8'd0, 0, 2'b00, 0, 0, 1};  // load when loaded: ignored
        tbl[1] = '{0, 0, 0, 8'd0, 0, 2'b00, 0, 0, 1};
        tbl[2] = '{0, 0, 1, 8'd0, 0, 2'b00, 1, 0, 1};  // zero pairs: straight to done
        tbl[3] = '{0, 0, 0, 8'd0, 0, 2'b00, 0, 0, 1};
        tbl[4] = '{1, 0, 0, 8'd0, 0, 2'b00, 0, 0, 0};  // reset clears loaded
        tbl[5] = '{0, 0, 1, 8'd3, 0, 2'b00, 0, 0, 0};  // exec before load: ignored
        tbl[6] = '{0, 1, 1, 8'd3, 0, 2'b00, 0, 1, 0};  // both: load wins
        tbl[7] = '{0, 0, 0, 8'd0, 0, 2'b00, 0, 1, 0};  // starved in LOAD
        for (int i = 0; i < 8; i++) begin
            reset = tbl[i].rst; start_load = tbl[i].sl; start_exec = tbl[i].se;
            cfg_pairs = tbl[i].cfg; in_valid = tbl[i].iv;
            step();
            check("tbl_inst",   32'(inst_w), 32'(tbl[i].e_inst));
            check("tbl_done",   32'(done),   32'(tbl[i].e_done));
            check("tbl_busy",   32'(busy),   32'(tbl[i].e_busy));
            check("tbl_loaded", 32'(loaded), 32'(tbl[i].e_loaded));
        end
        reset = 1'b0;

        // Reset in the middle of LOAD, at beat 5
        in_valid = 1'b1;
        for (int i = 0; i < 5; i++) step();
        check("beat5_inst", 32'(inst_w), 32'd1);
        reset = 1'b1;
        step();
        check("abort_busy",   32'(busy),   32'd0);
        check("abort_inst",   32'(inst_w), 32'd0);
        check("abort_loaded", 32'(loaded), 32'd0);
        reset = 1'b0;
        in_valid = 1'b0;
        step();
        start_load = 1'b1; in_valid = 1'b1;
        step();
        run_phase(-1, 0, nl, ne);
        check("reload_beats", 32'(nl), 32'(2 * COL));
        step();

        // Randomized traffic against the model
        for (int i = 0; i < 1500; i++) begin
            reset      = ($urandom_range(0, 299) == 0);
            start_load = ($urandom_range(0, 29) == 0);
            start_exec = ($urandom_range(0, 9) == 0);
            cfg_pairs  = 8'($urandom_range(0, 12));
            in_valid   = ($urandom_range(0, 3) != 0);
            step();
        end

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule

// File: doc/row_feeder.md
ROW_FEEDER -- requirements
Module: row_feeder

Interface
REQ-001 Parameter bw, default 4, activation/weight width in bits.
REQ-002 Parameter col, default 8, number of mac_tile columns in the driven row.
REQ-003 Port clk  input  1  sole clock, rising edge.
REQ-004 Port reset  input  1  synchronous, active-high reset.
REQ-005 Port in_data  input  bw  next weight or activation from the upstream buffer.
REQ-006 Port in_valid  input  1  in_data holds a valid beat.
REQ-007 Port in_ready  output  1  feeder accepts in_data this cycle.
REQ-008 Port start_load  input  1  single-cycle pulse that begins the kernel-load phase.
REQ-009 Port start_exec  input  1  single-cycle pulse that begins the execute phase.
REQ-010 Port cfg_pairs  input  8  number of activation pairs to execute, sampled on an accepted start_exec.
REQ-011 Port out_w  output  bw  drives the west data input of tile 0.
REQ-012 Port inst_w  output  2  drives the tile instruction: bit1 execute, bit0 kernel load.
REQ-013 Port busy  output  1  feeder is in LOAD or EXEC.
REQ-014 Port done  output  1  one-cycle pulse when a phase completes.
REQ-015 Port loaded  output  1  kernel load has completed since the last reset.

Function
REQ-016 Feeder SHALL implement the states IDLE, LOAD, EXEC and DONE.
REQ-017 IDLE->LOAD on start_load when loaded=0; IDLE->EXEC on start_exec when loaded=1 and cfg_pairs!=0.
- start_load when loaded=1 is ignored.
- start_exec when loaded=0 is ignored.
REQ-018 If start_load and start_exec arrive together in IDLE, start_load SHALL win; start_exec is dropped.
REQ-019 Start pulses in any state other than IDLE SHALL be ignored.
REQ-020 start_exec with cfg_pairs=0 and loaded=1 SHALL go IDLE->DONE with no beats issued.
REQ-021 in_ready SHALL be 1 only in LOAD or EXEC while beats remain.
- A beat transfers when in_valid and in_ready are both 1.
REQ-022 LOAD SHALL transfer exactly 2*col beats; EXEC SHALL transfer exactly 2*cfg_pairs beats.
- Beat counter width: clog2(512).
REQ-023 out_w and inst_w SHALL be registered.
- A beat accepted in cycle N appears on out_w in cycle N+1.
- In that cycle, inst_w=2'b01 for a LOAD beat and 2'b10 for an EXEC beat.
REQ-024 In every cycle without a transfer (stall, IDLE, DONE), inst_w SHALL be 2'b00 and out_w SHALL hold its previous value.
- This keeps the tile's pair counter aligned across stalls.
REQ-025 After the last beat is accepted, the state SHALL go to DONE; DONE lasts one cycle, asserts done, then returns to IDLE.
REQ-026 loaded SHALL set in the cycle DONE is entered from LOAD and stay set until reset.
REQ-027 busy = (state==LOAD || state==EXEC), decoded combinationally from the state register.

Reset
REQ-028 On reset, the following SHALL apply:
- state=IDLE.
- out_w=0, inst_w=2'b00.
- in_ready=0, done=0, loaded=0.
- Beat counter = 0.
REQ-029 Reset during LOAD or EXEC SHALL abort the phase, clear loaded, and issue no further beats.
- Reset matches the tile's own reset, so tile load state and feeder state stay consistent.

Configuration
REQ-030 With FEEDER_STALL_CNT_EN defined, the feeder SHALL add port stall_cnt, output, 16 bits.
- stall_cnt increments in each LOAD or EXEC cycle with in_ready=1 and in_valid=0.
- stall_cnt saturates at 16'hFFFF.
- stall_cnt clears on reset and on each accepted start.
REQ-031 Without FEEDER_STALL_CNT_EN, the port and its logic SHALL be absent; all other behaviour is identical.

Structure
REQ-032 Package feeder_pkg SHALL hold the state typedef and the constants INST_NOP=2'b00, INST_LOAD=2'b01, INST_EXEC=2'b10.
REQ-033 The block SHALL be a single module with no sub-module; the beat counter and FSM are inline.

Verification
REQ-034 Bench SHALL cover the following directed scenarios:
- Reset, then start_load with in_valid held high, col=8 -> 16 consecutive cycles of inst_w=01, out_w following in_data one cycle late, then done=1 for one cycle, then loaded=1.
- After load, start_exec with cfg_pairs=3 and in_valid high -> 6 cycles of inst_w=10, then done; a second start_exec works.
- EXEC with in_valid low for 2 cycles after the 3rd beat -> inst_w=00 in those cycles, out_w held, 6 beats total; stall_cnt=2 when FEEDER_STALL_CNT_EN is defined.
- start_exec before load; start_load after loaded; start_exec with cfg_pairs=0 -> first two ignored (inst_w stays 00), third gives done next cycle with no beats.
- start_load and start_exec in the same cycle -> LOAD entered.
- Reset asserted at LOAD beat 5 -> next cycle IDLE, inst_w=00, loaded=0; a fresh start_load issues 16 beats.
